ibex_irq_ctrl: RTL
==================

Name: ibex_irq_ctrl

Overview:
- Memory-mapped interrupt source block on the data bus. It is the producer side of the core's interrupt inputs and drives a packed irqs_t plus irq_nm_o.
- Contains a 64-bit mtime/mtimecmp timer with prescaler, a software-interrupt bit, and 15 fast-interrupt latches with per-line enable and edge/level mode.
- Responds to core load/store requests using the core's req/gnt/rvalid handshake.

Parameters:
- MtimeResetVal, 64'h0, reset value of mtime.
- PrescaleResetVal, 8'd0, reset value of PRESCALE. Period between mtime increments is PRESCALE+1 cycles.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- req_i  in  1  bus request
- we_i  in  1  write enable
- be_i  in  4  byte enables
- addr_i  in  12  byte address offset; bits [1:0] ignored
- wdata_i  in  32  write data
- gnt_o  out  1  grant
- rvalid_o  out  1  response valid
- rdata_o  out  32  read data
- err_o  out  1  error, qualified by rvalid_o
- irq_fast_src_i  in  15  fast interrupt sources, synchronous to clk_i
- irq_ext_i  in  1  external interrupt, level
- nmi_src_i  in  1  NMI source, rising-edge
- irqs_o  out  18  irqs_t: {software, timer, external, fast[14:0]}
- irq_nm_o  out  1  non-maskable interrupt

Behaviour:
- Reset values: all outputs 0; mtime=MtimeResetVal; mtimecmp=64'hFFFF_FFFF_FFFF_FFFF; PRESCALE=PrescaleResetVal; prescale counter 0; MSIP/FIP/FIE/FMODE 0; NMI latch 0; all edge-detect history flops 0.
- Register map (byte offsets):
  - 0x000 MSIP[0]
  - 0x008/0x00C MTIMECMP lo/hi
  - 0x010/0x014 MTIME lo/hi
  - 0x018 PRESCALE[7:0]
  - 0x020 FIP[14:0], write-1-to-clear
  - 0x024 FIE[14:0]
  - 0x028 FMODE[14:0], 1 = edge, 0 = level
  - 0x02C NMI[0], write-1-to-clear
  - Unimplemented bits read 0.
- Handshake:
  - gnt_o = req_i combinationally; every request is granted the cycle it is asserted.
  - rvalid_o asserts exactly 1 cycle after each grant.
  - rdata_o is registered: the value at the grant cycle for reads, 0 for writes.
  - Back-to-back requests give back-to-back rvalid.
- Writes update state at the grant clock edge, per byte lane via be_i. be_i=0 is a legal no-op.
- Unmapped offset: no state change, rvalid_o with err_o=1, rdata_o=0.
- Prescaler: the counter increments each cycle. When counter==PRESCALE, the counter goes to 0 and mtime increments by 1. 64-bit wrap FFFF..F -> 0 with no flag.
- A bus write to MTIME lo or hi has priority over that cycle's increment and resets the prescale counter to 0. Writing the other half leaves that half untouched.
- Writing PRESCALE resets the prescale counter to 0.
- Timer interrupt: irqs_o.irq_timer is registered (mtime >= mtimecmp), unsigned 64-bit, so it lags the compare by 1 cycle. It clears the cycle after a mtimecmp write makes the compare false.
- irqs_o.irq_software is registered MSIP[0].
- irqs_o.irq_external is registered irq_ext_i.
- Fast interrupts, per line i:
  - Edge mode: a rising edge of irq_fast_src_i[i] sets FIP[i]; W1C clears it. Simultaneous set and clear: set wins.
  - Level mode: FIP[i] follows the source each cycle; W1C is ignored.
  - irqs_o.irq_fast[i] = registered FIP[i] & FIE[i].
  - Changing FMODE takes effect the next cycle; the history flop is always tracking.
- NMI: a rising edge of nmi_src_i sets the latch; W1C clears it; set wins. irq_nm_o = latch, registered.
- Reset asserted mid-transaction: a pending rvalid is dropped and no response is issued after reset.

Decomposition:
- Package additions: byte-offset localparams (IRQ_CTRL_MSIP_OFF ... IRQ_CTRL_NMI_OFF) and a fast-mode enum (FIRQ_LEVEL=1'b0, FIRQ_EDGE=1'b1). Reuse the existing irqs_t.
- Sub-module ibex_irq_ctrl_timer: prescaler, mtime, mtimecmp, compare flop, and write-priority logic. The top module keeps bus decode and the interrupt latches.

Test Plan:
- Reset, then read 0x008/0x00C -> rdata FFFFFFFF both, rvalid 1 cycle after req, err 0; irqs_o=0, irq_nm_o=0.
- PRESCALE=3, MTIMECMP={0,10}, MTIME=0 -> irq_timer rises at exactly 40 cycles after the MTIME write, +1 register; write MTIMECMP lo=100 -> irq_timer 0 next cycle.
- MTIME={FFFFFFFF,FFFFFFFF}, PRESCALE=0 -> next cycle reads MTIME hi=0, lo=0; write MTIME lo coincident with tick -> written value kept, not +1.
- FMODE[3]=1, FIE[3]=1, pulse irq_fast_src_i[3] 1 cycle -> FIP=0x8 and irq_fast[3]=1; W1C 0x8 in the same cycle as a new edge -> FIP[3] stays 1.
- FMODE[5]=0, FIE[5]=0, hold src[5]=1 -> FIP[5]=1, irq_fast[5]=0; set FIE[5] -> irq_fast[5]=1; drop src -> clears in 2 cycles.
- Read 0x0F0 -> err_o=1, rdata 0; write be_i=4'b0010 to FIE with 0x0000FF00 -> FIE=0x7F00 (bit 15 unimplemented).

Source files
------------

// File: rtl/ibex_irq_ctrl_pkg.sv
// Shared types and register offsets for the memory-mapped interrupt source block.
package ibex_irq_ctrl_pkg;

    typedef struct packed {
        logic        irq_software;
        logic        irq_timer;
        logic        irq_external;
        logic [14:0] irq_fast;
    } irqs_t;

    typedef enum logic {
        FIRQ_LEVEL = 1'b0,
        FIRQ_EDGE  = 1'b1
    } firq_mode_e;

    localparam logic [11:0] IRQ_CTRL_MSIP_OFF    = 12'h000;
    localparam logic [11:0] IRQ_CTRL_CMP_LO_OFF  = 12'h008;
    localparam logic [11:0] IRQ_CTRL_CMP_HI_OFF  = 12'h00C;
    localparam logic [11:0] IRQ_CTRL_TIME_LO_OFF = 12'h010;
    localparam logic [11:0] IRQ_CTRL_TIME_HI_OFF = 12'h014;
    localparam logic [11:0] IRQ_CTRL_PRESC_OFF   = 12'h018;
    localparam logic [11:0] IRQ_CTRL_FIP_OFF     = 12'h020;
    localparam logic [11:0] IRQ_CTRL_FIE_OFF     = 12'h024;
    localparam logic [11:0] IRQ_CTRL_FMODE_OFF   = 12'h028;
    localparam logic [11:0] IRQ_CTRL_NMI_OFF     = 12'h02C;

    function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

    function automatic logic [14:0] lane15(input logic [14:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
        logic [14:0] res;
        res[7:0]  = be[0] ? new_val[7:0]  : old_val[7:0];
        res[14:8] = be[1] ? new_val[14:8] : old_val[14:8];
        return res;
    endfunction

endpackage

// File: rtl/ibex_irq_ctrl_timer.sv
// mtime/mtimecmp timer with prescaler; bus writes take priority over ticks.
module ibex_irq_ctrl_timer
    import ibex_irq_ctrl_pkg::*;
#(
    parameter logic [63:0] MtimeResetVal    = 64'h0,
    parameter logic [7:0]  PrescaleResetVal = 8'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic        cmp_lo_we_i,
    input  logic        cmp_hi_we_i,
    input  logic        time_lo_we_i,
    input  logic        time_hi_we_i,
    input  logic        presc_we_i,
    output logic [63:0] mtime_o,
    output logic [63:0] mtimecmp_o,
    output logic [7:0]  prescale_o,
    output logic        irq_timer_o
);

    logic [63:0] mtime_q, mtime_d;
    logic [63:0] cmp_q, cmp_d;
    logic [7:0]  presc_q, presc_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        irq_q;
    logic        tick;

    always_comb begin
        tick    = (cnt_q == presc_q);
        cnt_d   = tick ? 8'd0 : cnt_q + 8'd1;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        cmp_d   = cmp_q;
        presc_d = presc_q;

        // A software write to either half freezes mtime for that cycle.
        if (time_lo_we_i || time_hi_we_i) begin
            mtime_d = mtime_q;
            cnt_d   = 8'd0;
        end
        if (time_lo_we_i) begin
            mtime_d[31:0] = be_merge(mtime_q[31:0], wdata_i, be_i);
        end
        if (time_hi_we_i) begin
            mtime_d[63:32] = be_merge(mtime_q[63:32], wdata_i, be_i);
        end
        if (cmp_lo_we_i) begin
            cmp_d[31:0] = be_merge(cmp_q[31:0], wdata_i, be_i);
        end
        if (cmp_hi_we_i) begin
            cmp_d[63:32] = be_merge(cmp_q[63:32], wdata_i, be_i);
        end
        if (presc_we_i) begin
            presc_d = be_i[0] ? wdata_i[7:0] : presc_q;
            cnt_d   = 8'd0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mtime_q <= MtimeResetVal;
            cmp_q   <= 64'hFFFF_FFFF_FFFF_FFFF;
            presc_q <= PrescaleResetVal;
            cnt_q   <= 8'd0;
            irq_q   <= 1'b0;
        end else begin
            mtime_q <= mtime_d;
            cmp_q   <= cmp_d;
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
            irq_q   <= (mtime_q >= cmp_q);
        end
    end

    assign mtime_o     = mtime_q;
    assign mtimecmp_o  = cmp_q;
    assign prescale_o  = presc_q;
    assign irq_timer_o = irq_q;

endmodule

// File: rtl/ibex_irq_ctrl.sv
// Memory-mapped interrupt sources: bus decode, fast-irq latches, MSIP, NMI.
module ibex_irq_ctrl
    import ibex_irq_ctrl_pkg::*;
#(
    parameter logic [63:0] MtimeResetVal    = 64'h0,
    parameter logic [7:0]  PrescaleResetVal = 8'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [11:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        gnt_o,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    input  logic [14:0] irq_fast_src_i,
    input  logic        irq_ext_i,
    input  logic        nmi_src_i,
    output irqs_t       irqs_o,
    output logic        irq_nm_o
);

    logic [11:0] off;
    logic        hit_msip, hit_cmp_lo, hit_cmp_hi, hit_time_lo, hit_time_hi;
    logic        hit_presc, hit_fip, hit_fie, hit_fmode, hit_nmi, hit_any;
    logic        wr_en, rd_en;
    logic        unused_addr;

    logic [63:0] mtime, mtimecmp;
    logic [7:0]  prescale;
    logic        irq_timer;

    logic        msip_q, msip_d;
    logic [14:0] fip_q, fip_d, fie_q, fie_d, fmode_q, fmode_d;
    logic [14:0] hist_q, fast_rise, fip_clr;
    logic        nmi_q, nmi_d, nmi_hist_q;

    logic        irq_sw_q, irq_ext_q, irq_nm_q;
    logic [14:0] irq_fast_q;

    logic        rvalid_q, err_q, err_d;
    logic [31:0] rdata_q, rdata_d, rd_val;

    assign off         = {addr_i[11:2], 2'b00};
    assign unused_addr = ^addr_i[1:0];

    assign hit_msip    = (off == IRQ_CTRL_MSIP_OFF);
    assign hit_cmp_lo  = (off == IRQ_CTRL_CMP_LO_OFF);
    assign hit_cmp_hi  = (off == IRQ_CTRL_CMP_HI_OFF);
    assign hit_time_lo = (off == IRQ_CTRL_TIME_LO_OFF);
    assign hit_time_hi = (off == IRQ_CTRL_TIME_HI_OFF);
    assign hit_presc   = (off == IRQ_CTRL_PRESC_OFF);
    assign hit_fip     = (off == IRQ_CTRL_FIP_OFF);
    assign hit_fie     = (off == IRQ_CTRL_FIE_OFF);
    assign hit_fmode   = (off == IRQ_CTRL_FMODE_OFF);
    assign hit_nmi     = (off == IRQ_CTRL_NMI_OFF);
    assign hit_any     = hit_msip | hit_cmp_lo | hit_cmp_hi | hit_time_lo
                       | hit_time_hi | hit_presc | hit_fip | hit_fie
                       | hit_fmode | hit_nmi;

    // An all-zero byte enable must not disturb anything, including the prescaler.
    assign wr_en = req_i & we_i & (|be_i);
    assign rd_en = req_i & ~we_i;

    ibex_irq_ctrl_timer #(
        .MtimeResetVal    (MtimeResetVal),
        .PrescaleResetVal (PrescaleResetVal)
    ) u_timer (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .be_i         (be_i),
        .wdata_i      (wdata_i),
        .cmp_lo_we_i  (wr_en & hit_cmp_lo),
        .cmp_hi_we_i  (wr_en & hit_cmp_hi),
        .time_lo_we_i (wr_en & hit_time_lo),
        .time_hi_we_i (wr_en & hit_time_hi),
        .presc_we_i   (wr_en & hit_presc),
        .mtime_o      (mtime),
        .mtimecmp_o   (mtimecmp),
        .prescale_o   (prescale),
        .irq_timer_o  (irq_timer)
    );

    always_comb begin
        msip_d    = msip_q;
        fie_d     = fie_q;
        fmode_d   = fmode_q;
        fip_clr   = '0;
        fast_rise = irq_fast_src_i & ~hist_q;

        if (wr_en && hit_msip && be_i[0]) msip_d = wdata_i[0];
        if (wr_en && hit_fie)   fie_d   = lane15(fie_q, wdata_i, be_i);
        if (wr_en && hit_fmode) fmode_d = lane15(fmode_q, wdata_i, be_i);
        if (wr_en && hit_fip)   fip_clr = lane15(15'd0, wdata_i, be_i);

        for (int i = 0; i < 15; i++) begin
            if (fmode_q[i] == FIRQ_EDGE) begin
                fip_d[i] = fast_rise[i] | (fip_q[i] & ~fip_clr[i]);
            end else begin
                fip_d[i] = irq_fast_src_i[i];
            end
        end

        nmi_d = (nmi_src_i & ~nmi_hist_q)
              | (nmi_q & ~(wr_en & hit_nmi & be_i[0] & wdata_i[0]));
    end

    always_comb begin
        rd_val = '0;
        unique case (1'b1)
            hit_msip:    rd_val = {31'd0, msip_q};
            hit_cmp_lo:  rd_val = mtimecmp[31:0];
            hit_cmp_hi:  rd_val = mtimecmp[63:32];
            hit_time_lo: rd_val = mtime[31:0];
            hit_time_hi: rd_val = mtime[63:32];
            hit_presc:   rd_val = {24'd0, prescale};
            hit_fip:     rd_val = {17'd0, fip_q};
            hit_fie:     rd_val = {17'd0, fie_q};
            hit_fmode:   rd_val = {17'd0, fmode_q};
            hit_nmi:     rd_val = {31'd0, nmi_q};
            default:     rd_val = '0;
        endcase
        rdata_d = rd_en ? rd_val : 32'd0;
        err_d   = req_i & ~hit_any;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            msip_q     <= 1'b0;
            fip_q      <= '0;
            fie_q      <= '0;
            fmode_q    <= '0;
            hist_q     <= '0;
            nmi_q      <= 1'b0;
            nmi_hist_q <= 1'b0;
            irq_sw_q   <= 1'b0;
            irq_ext_q  <= 1'b0;
            irq_fast_q <= '0;
            irq_nm_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            msip_q     <= msip_d;
            fip_q      <= fip_d;
            fie_q      <= fie_d;
            fmode_q    <= fmode_d;
            hist_q     <= irq_fast_src_i;
            nmi_q      <= nmi_d;
            nmi_hist_q <= nmi_src_i;
            irq_sw_q   <= msip_q;
            irq_ext_q  <= irq_ext_i;
            irq_fast_q <= fip_q & fie_q;
            irq_nm_q   <= nmi_q;
            rvalid_q   <= req_i;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign gnt_o    = req_i;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign err_o    = err_q;
    assign irq_nm_o = irq_nm_q;

    assign irqs_o.irq_software = irq_sw_q;
    assign irqs_o.irq_timer    = irq_timer;
    assign irqs_o.irq_external = irq_ext_q;
    assign irqs_o.irq_fast     = irq_fast_q;

endmodule
